// File: rtl/fwd_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package     : fwd_pkg                                                  |
// | Description : Shared constants and stall-FSM state type for the        |
// |               operand-forwarding / hazard unit.                        |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
package fwd_pkg;

    // EX operand mux encoding: 0 takes the ID/regfile value,
    // SEL_STAGE_BASE + k takes the result held in downstream stage k.
    localparam int SEL_REGFILE    = 0;
    localparam int SEL_STAGE_BASE = 1;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_BUBBLE = 1'b1
    } stall_state_e;

endpackage : fwd_pkg
`default_nettype wire

// File: rtl/fwd_hazard_unit_p_resolve.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : fwd_src_resolve                                          |
// | Description : Combinational producer match for one consumer source.    |
// |               Produces the next EX mux select (youngest producer       |
// |               wins), the EX-stage match and a RAW hit against any      |
// |               producer that has not yet reached the last stage.        |
// | Ports       : src_addr_i/src_used_i      consumer operand              |
// |               ex_dest_i/ex_wb_en_i       producer in EX                |
// |               stage_dest_i/stage_wb_en_i downstream producers          |
// |               next_sel_o, m_ex_o, raw_hit_o                            |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module fwd_src_resolve
    import fwd_pkg::*;
#(
    parameter int REG_W      = 4,
    parameter int NUM_STAGES = 2,
    parameter int SEL_W      = 2
) (
    input  logic [REG_W-1:0]            src_addr_i,
    input  logic                        src_used_i,
    input  logic [REG_W-1:0]            ex_dest_i,
    input  logic                        ex_wb_en_i,
    input  logic [NUM_STAGES*REG_W-1:0] stage_dest_i,
    input  logic [NUM_STAGES-1:0]       stage_wb_en_i,
    output logic [SEL_W-1:0]            next_sel_o,
    output logic                        m_ex_o,
    output logic                        raw_hit_o
);

    logic [NUM_STAGES-1:0] w_m_st;
    // The last stage writes through the register file, so its match never
    // drives a select or a hazard.
    logic                  w_unused_last_match;

    always_comb begin
        for (int k = 0; k < NUM_STAGES; k++) begin
            w_m_st[k] = src_used_i & stage_wb_en_i[k] &
                        (src_addr_i == stage_dest_i[k*REG_W +: REG_W]);
        end
    end

    assign m_ex_o              = src_used_i & ex_wb_en_i & (src_addr_i == ex_dest_i);
    assign w_unused_last_match = w_m_st[NUM_STAGES-1];

    // The consumer enters EX as the producer advances one stage, so a match
    // in EX selects stage 0 and a match in stage k selects stage k+1.
    // Scanning oldest to youngest lets the youngest producer overwrite.
    always_comb begin
        next_sel_o = SEL_W'(SEL_REGFILE);
        raw_hit_o  = m_ex_o;
        for (int k = NUM_STAGES - 2; k >= 0; k--) begin
            if (w_m_st[k]) begin
                next_sel_o = SEL_W'(SEL_STAGE_BASE + k + 1);
            end
            raw_hit_o = raw_hit_o | w_m_st[k];
        end
        if (m_ex_o) begin
            next_sel_o = SEL_W'(SEL_STAGE_BASE);
        end
    end

endmodule : fwd_src_resolve
`default_nettype wire

// File: rtl/fwd_hazard_unit_p.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : fwd_hazard_unit_p                                        |
// | Description : Operand forwarding and hazard unit. Resolves consumer    |
// |               sources in ID against EX and downstream producers,       |
// |               registers the EX mux selects, raises load-use and        |
// |               no-forwarding stalls and counts stalled cycles.          |
// | Ports       : clk, rst (async, active-low), forwarding_en, flush,      |
// |               id_valid, src_addr, src_used, ex_dest, ex_wb_en,         |
// |               ex_mem_read, stage_dest, stage_wb_en                     |
// |               -> sel_src, stall, stall_cnt                             |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module fwd_hazard_unit_p
    import fwd_pkg::*;
#(
    parameter int NUM_SRC        = 3,
    parameter int REG_W          = 4,
    parameter int NUM_STAGES     = 2,
    parameter int LOAD_STALL_CYC = 1,
    parameter int CNT_W          = 16,
    localparam int SEL_W         = $clog2(NUM_STAGES + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        forwarding_en,
    input  logic                        flush,
    input  logic                        id_valid,
    input  logic [NUM_SRC*REG_W-1:0]    src_addr,
    input  logic [NUM_SRC-1:0]          src_used,
    input  logic [REG_W-1:0]            ex_dest,
    input  logic                        ex_wb_en,
    input  logic                        ex_mem_read,
    input  logic [NUM_STAGES*REG_W-1:0] stage_dest,
    input  logic [NUM_STAGES-1:0]       stage_wb_en,
    output logic [NUM_SRC*SEL_W-1:0]    sel_src,
    output logic                        stall,
    output logic [CNT_W-1:0]            stall_cnt
);

    localparam int BCNT_W      = $clog2(LOAD_STALL_CYC + 1);
    // The IDLE cycle that detects the hazard is the first bubble.
    localparam int BUBBLE_INIT = (LOAD_STALL_CYC > 1) ? LOAD_STALL_CYC - 2 : 0;

    logic [NUM_SRC*SEL_W-1:0] w_next_sel;
    logic [NUM_SRC-1:0]       w_m_ex;
    logic [NUM_SRC-1:0]       w_raw_hit;
    logic                     w_load_use;
    logic                     w_raw_nf;
    logic                     w_stall;

    stall_state_e             state_q, state_d;
    logic [BCNT_W-1:0]        bcnt_q, bcnt_d;
    logic [NUM_SRC*SEL_W-1:0] sel_q, sel_d;
    logic [CNT_W-1:0]         stall_cnt_q;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        fwd_src_resolve #(
            .REG_W      (REG_W),
            .NUM_STAGES (NUM_STAGES),
            .SEL_W      (SEL_W)
        ) u_resolve (
            .src_addr_i    (src_addr[i*REG_W +: REG_W]),
            .src_used_i    (src_used[i]),
            .ex_dest_i     (ex_dest),
            .ex_wb_en_i    (ex_wb_en),
            .stage_dest_i  (stage_dest),
            .stage_wb_en_i (stage_wb_en),
            .next_sel_o    (w_next_sel[i*SEL_W +: SEL_W]),
            .m_ex_o        (w_m_ex[i]),
            .raw_hit_o     (w_raw_hit[i])
        );
    end

    assign w_load_use = forwarding_en & ex_mem_read & (|w_m_ex);
    assign w_raw_nf   = ~forwarding_en & (|w_raw_hit);

    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        w_stall = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                w_stall = id_valid & (w_load_use | w_raw_nf);
                if (w_stall && w_load_use && (LOAD_STALL_CYC > 1)) begin
                    state_d = ST_BUBBLE;
                    bcnt_d  = BCNT_W'(BUBBLE_INIT);
                end
            end
            ST_BUBBLE: begin
                w_stall = 1'b1;
                if (bcnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    bcnt_d = bcnt_q - BCNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                bcnt_d  = '0;
            end
        endcase
        if (flush) begin
            w_stall = 1'b0;
            state_d = ST_IDLE;
            bcnt_d  = '0;
        end
        // Keep stall low while reset is held so every output reads zero.
        if (!rst) begin
            w_stall = 1'b0;
        end
    end

    // A bubble entering EX, or forwarding being off, must read the regfile.
    always_comb begin
        sel_d = w_next_sel;
        if (flush || w_stall || !id_valid || !forwarding_en) begin
            sel_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            bcnt_q      <= '0;
            sel_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            sel_q   <= sel_d;
            if (w_stall && !(&stall_cnt_q)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
        end
    end

    assign sel_src   = sel_q;
    assign stall     = w_stall;
    assign stall_cnt = stall_cnt_q;

endmodule : fwd_hazard_unit_p
`default_nettype wire
